// File: rtl/hazard_sched_unit.sv
// Hazard scheduler for the 5-stage RV32I pipeline: forwarding selects, load-use stall, branch flush.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_sched_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [REG_AW-1:0] rd_ID,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic [1:0]        hazard_optype_ID,
  input  logic              Branch_ID,
  output logic [1:0]        forward_ctrl_A,
  output logic [1:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EX_ALU  = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  // Only EX and MEM shadows are kept: WB is never a forwarding source (write-first
  // regfile) and its ls bit is not observed, so a WB copy would be dead state.
  logic [REG_AW-1:0] ex_rd;
  logic [1:0]        ex_op;
  logic              ex_ls;
  logic [REG_AW-1:0] mem_rd;
  logic [1:0]        mem_op;
  logic              mem_ls;

  logic ex_writes;
  logic mem_writes;
  logic m_ex1;
  logic m_ex2;
  logic m_mem1;
  logic m_mem2;
  logic rs1_hit_ex;
  logic rs2_hit_ex;
  logic load_in_ex;
  logic store_bypass;
  logic load_use;

  assign ex_writes  = (ex_op == OP_ALU) || (ex_op == OP_LOAD);
  assign mem_writes = (mem_op == OP_ALU) || (mem_op == OP_LOAD);

  assign m_ex1  = (rs1_ID != '0) && (rs1_ID == ex_rd)  && ex_writes;
  assign m_ex2  = (rs2_ID != '0) && (rs2_ID == ex_rd)  && ex_writes;
  assign m_mem1 = (rs1_ID != '0) && (rs1_ID == mem_rd) && mem_writes;
  assign m_mem2 = (rs2_ID != '0) && (rs2_ID == mem_rd) && mem_writes;

  function automatic logic [1:0] fwd_sel(
    input logic       rd_used,
    input logic       hit_ex,
    input logic [1:0] op_ex,
    input logic       hit_mem,
    input logic [1:0] op_mem
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rd_used) begin
      if (hit_ex && op_ex == OP_ALU)
        sel = FWD_EX_ALU;
      else if (hit_mem && op_mem == OP_ALU)
        sel = FWD_MEM_ALU;
      else if (hit_mem && op_mem == OP_LOAD)
        sel = FWD_MEM_LD;
    end
    return sel;
  endfunction

  assign forward_ctrl_A  = fwd_sel(rs1use_ID, m_ex1, ex_op, m_mem1, mem_op);
  assign forward_ctrl_B  = fwd_sel(rs2use_ID, m_ex2, ex_op, m_mem2, mem_op);
  assign forward_ctrl_ls = mem_ls;

  assign rs1_hit_ex = rs1use_ID && m_ex1;
  assign rs2_hit_ex = rs2use_ID && m_ex2;
  assign load_in_ex = (ex_op == OP_LOAD);

  // A store whose only dependency is its data operand can pick the load result up
  // from WB while the store sits in MEM, so it need not stall.
  assign store_bypass = load_in_ex && (hazard_optype_ID == OP_STORE)
                        && rs2_hit_ex && !rs1_hit_ex;
  assign load_use     = load_in_ex && (rs1_hit_ex || rs2_hit_ex) && !store_bypass;

  assign PC_EN_IF     = !load_use;
  assign reg_FD_EN    = !load_use;
  assign reg_DE_flush = load_use;
  assign reg_FD_flush = Branch_ID && !load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd  <= '0;
      ex_op  <= OP_NONE;
      ex_ls  <= 1'b0;
      mem_rd <= '0;
      mem_op <= OP_NONE;
      mem_ls <= 1'b0;
    end else begin
      if (load_use) begin
        ex_rd <= '0;
        ex_op <= OP_NONE;
        ex_ls <= 1'b0;
      end else begin
        ex_rd <= rd_ID;
        ex_op <= hazard_optype_ID;
        ex_ls <= store_bypass;
      end
      mem_rd <= ex_rd;
      mem_op <= ex_op;
      mem_ls <= ex_ls;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_use)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (reg_FD_flush)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sched_unit.sv
// Scoreboard bench for hazard_sched_unit: directed instruction sequences with hand-computed
// expectations, checked by a monitor at each falling edge. Honours HAZARD_PERF_CNT_EN for counters.
module tb_hazard_sched_unit;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;
  localparam logic [1:0] NO = 2'b00, AL = 2'b01, LD = 2'b10, ST = 2'b11;

  logic              clk;
  logic              rst_n;
  logic [REG_AW-1:0] rs1_ID, rs2_ID, rd_ID;
  logic              rs1use_ID, rs2use_ID;
  logic [1:0]        hazard_optype_ID;
  logic              Branch_ID;
  logic [1:0]        forward_ctrl_A, forward_ctrl_B;
  logic              forward_ctrl_ls, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  hazard_sched_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
    .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
    .hazard_optype_ID(hazard_optype_ID), .Branch_ID(Branch_ID),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls), .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
    .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             fls;
    logic             pc;
    logic             fd;
    logic             fdfl;
    logic             defl;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] fcnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    stall_acc = 0;
  int    flush_acc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [CNT_W-1:0] act,
                     input logic [CNT_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, "fwdA",     CNT_W'(forward_ctrl_A),  CNT_W'(e.fa));
      chk(nm, "fwdB",     CNT_W'(forward_ctrl_B),  CNT_W'(e.fb));
      chk(nm, "fwdLS",    CNT_W'(forward_ctrl_ls), CNT_W'(e.fls));
      chk(nm, "PC_EN",    CNT_W'(PC_EN_IF),        CNT_W'(e.pc));
      chk(nm, "FD_EN",    CNT_W'(reg_FD_EN),       CNT_W'(e.fd));
      chk(nm, "FD_flush", CNT_W'(reg_FD_flush),    CNT_W'(e.fdfl));
      chk(nm, "DE_flush", CNT_W'(reg_DE_flush),    CNT_W'(e.defl));
      chk(nm, "stall_cnt", stall_cnt, e.scnt);
      chk(nm, "flush_cnt", flush_cnt, e.fcnt);
    end
  end

  // Counter expectations are the number of stall/flush cycles expected strictly before this one.
  task automatic push_exp(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                          input logic fls, input logic stall, input logic fdfl);
    exp_t e;
    e.fa   = fa;
    e.fb   = fb;
    e.fls  = fls;
    e.pc   = !stall;
    e.fd   = !stall;
    e.fdfl = fdfl;
    e.defl = stall;
`ifdef HAZARD_PERF_CNT_EN
    e.scnt = CNT_W'(stall_acc);
    e.fcnt = CNT_W'(flush_acc);
`else
    e.scnt = '0;
    e.fcnt = '0;
`endif
    if (stall) stall_acc++;
    if (fdfl)  flush_acc++;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input string nm, input int rs1, input int rs2, input int rd,
                      input logic u1, input logic u2, input logic [1:0] op, input logic br,
                      input logic [1:0] fa, input logic [1:0] fb, input logic fls,
                      input logic stall, input logic fdfl);
    @(posedge clk);
    #1;
    rs1_ID = REG_AW'(rs1);
    rs2_ID = REG_AW'(rs2);
    rd_ID  = REG_AW'(rd);
    rs1use_ID = u1;
    rs2use_ID = u2;
    hazard_optype_ID = op;
    Branch_ID = br;
    push_exp(nm, fa, fb, fls, stall, fdfl);
  endtask

  task automatic clear_inputs();
    rs1_ID = '0; rs2_ID = '0; rd_ID = '0;
    rs1use_ID = 1'b0; rs2use_ID = 1'b0;
    hazard_optype_ID = NO; Branch_ID = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #1;
    push_exp("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    #10 rst_n = 1'b1;

    //        name           rs1 rs2 rd u1 u2 op  br   fA     fB    ls  stall fdfl
    step("lw_x5",           1, 0, 5, 1, 0, LD, 0, 2'b00, 2'b00, 0, 0, 0);
    step("add_use_stall",   5, 7, 6, 1, 1, AL, 0, 2'b00, 2'b00, 0, 1, 0);
    step("add_use_fwd11",   5, 7, 6, 1, 1, AL, 0, 2'b11, 2'b00, 0, 0, 0);
    step("add_x5",          1, 2, 5, 1, 1, AL, 0, 2'b00, 2'b00, 0, 0, 0);
    step("sub_fwdB_ex",     7, 5, 8, 1, 1, AL, 0, 2'b00, 2'b01, 0, 0, 0);
    step("add_x5_b",        1, 2, 5, 1, 1, AL, 0, 2'b00, 2'b00, 0, 0, 0);
    step("indep",          11,12,10, 1, 1, AL, 0, 2'b00, 2'b00, 0, 0, 0);
    step("sub_fwdB_mem",    7, 5, 8, 1, 1, AL, 0, 2'b00, 2'b10, 0, 0, 0);
    step("add_x5_c",        1, 2, 5, 1, 1, AL, 0, 2'b00, 2'b00, 0, 0, 0);
    step("add_x5_d",        1, 2, 5, 1, 1, AL, 0, 2'b00, 2'b00, 0, 0, 0);
    step("ex_over_mem",     5, 5, 8, 1, 1, AL, 0, 2'b01, 2'b01, 0, 0, 0);
    step("lw_x5_st",        1, 0, 5, 1, 0, LD, 0, 2'b00, 2'b00, 0, 0, 0);
    step("sw_no_stall",     9, 5, 0, 1, 1, ST, 0, 2'b00, 2'b00, 0, 0, 0);
    step("nop_ls0",         0, 0, 0, 0, 0, NO, 0, 2'b00, 2'b00, 0, 0, 0);
    step("nop_ls1",         0, 0, 0, 0, 0, NO, 0, 2'b00, 2'b00, 1, 0, 0);
    step("nop_ls_off",      0, 0, 0, 0, 0, NO, 0, 2'b00, 2'b00, 0, 0, 0);
    step("branch_flush",    1, 2, 0, 1, 1, NO, 1, 2'b00, 2'b00, 0, 0, 1);
    step("lw_x5_br",        1, 0, 5, 1, 0, LD, 0, 2'b00, 2'b00, 0, 0, 0);
    step("branch_in_stall", 5, 6, 0, 1, 1, NO, 1, 2'b00, 2'b00, 0, 1, 0);
    step("branch_retry",    5, 6, 0, 1, 1, NO, 1, 2'b11, 2'b00, 0, 0, 1);
    step("lw_x9",           1, 0, 9, 1, 0, LD, 0, 2'b00, 2'b00, 0, 0, 0);
    step("sw_base_stall",   9, 9, 0, 1, 1, ST, 0, 2'b00, 2'b00, 0, 1, 0);
    step("sw_base_fwd",     9, 9, 0, 1, 1, ST, 0, 2'b11, 2'b11, 0, 0, 0);
    step("add_x0",          1, 2, 0, 1, 1, AL, 0, 2'b00, 2'b00, 0, 0, 0);
    step("read_x0",         0, 0, 1, 1, 1, AL, 0, 2'b00, 2'b00, 0, 0, 0);
    step("rs1use_off",      1, 0, 3, 0, 0, AL, 0, 2'b00, 2'b00, 0, 0, 0);
    step("lw_x5_rst",       2, 0, 5, 1, 0, LD, 0, 2'b00, 2'b00, 0, 0, 0);

    // Pulse reset while the load sits in EX; the pipeline must come back empty.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_inputs();
    #2;
    rst_n = 1'b1;
    stall_acc = 0;
    flush_acc = 0;

    step("after_rst_use",   5, 7, 6, 1, 1, AL, 0, 2'b00, 2'b00, 0, 0, 0);
    step("after_rst_nop",   0, 0, 0, 0, 0, NO, 0, 2'b00, 2'b00, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_sched_unit.md
Name: hazard_sched_unit

Overview:
- Pipeline hazard scheduler for the 5-stage RV32I core (IF/ID/EX/MEM/WB). Sits beside the decode-stage control unit.
- Consumes per-instruction hazard_optype, rs1use/rs2use, register indices and the resolved Branch signal.
- Keeps shadow copies of destination register and op class for EX, MEM and WB.
- Drives forwarding selects, load-use stalls, branch flushes and the load-to-store data forward.

Parameters:
- REG_AW, 5, register index width.
- CNT_W, 32, perf-counter width (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- rs1_ID  in  REG_AW  rs1 index of the instruction in ID.
- rs2_ID  in  REG_AW  rs2 index of the instruction in ID.
- rd_ID  in  REG_AW  rd index of the instruction in ID.
- rs1use_ID  in  1  rs1 is read.
- rs2use_ID  in  1  rs2 is read.
- hazard_optype_ID  in  2  op class: 00 none, 01 ALU, 10 LOAD, 11 STORE.
- Branch_ID  in  1  taken branch/jump resolved in ID.
- forward_ctrl_A  out  2  rs1 source: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data.
- forward_ctrl_B  out  2  rs2 source, same encoding.
- forward_ctrl_ls  out  1  store in MEM takes store data from WB load data.
- PC_EN_IF  out  1  PC update enable.
- reg_FD_EN  out  1  IF/ID register enable.
- reg_FD_flush  out  1  IF/ID register flush.
- reg_DE_flush  out  1  ID/EX register flush (bubble insert).
- stall_cnt  out  CNT_W  load-use stall cycle count.
- flush_cnt  out  CNT_W  branch flush count.

Behaviour:
- Shadow stages: each of EX, MEM, WB holds {rd, optype, ls}. Each stage advances every cycle: ID→EX, EX→MEM, MEM→WB. There is no global freeze; the MEM and WB stages never stall.
- Reset (async, rst_n=0): all shadow fields are 0 (bubble). Outputs take their combinational values for ID inputs evaluated against bubbles; with all ID inputs 0 this gives PC_EN_IF=1, reg_FD_EN=1, all other outputs 0. Counters are 0.
- Reset asserted mid-operation clears all in-flight hazard state immediately. The first cycle after release behaves as an empty pipeline.
- Match rule: match_X(rs) = rs != 0 && rs == rd_X && optype_X is ALU or LOAD. Register x0 never matches.
- Forward select per operand, only when its rsNuse is set; otherwise 00. Priority is highest first:
  - EX match with ALU → 01.
  - MEM match with ALU → 10.
  - MEM match with LOAD → 11.
  - Else 00.
  - WB is never forwarded; the regfile is write-first.
- load_use:
  - EX optype is LOAD and (rs1use && match_EX(rs1), or rs2use && match_EX(rs2)).
  - Exception: ID is STORE, only rs2 matches, and rs1 does not match EX → no stall; set ls=1 in the EX shadow next cycle.
- On load_use:
  - PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1.
  - EX shadow loads a bubble (optype 00, rd 0, ls 0) instead of the ID fields.
  - Stall lasts exactly 1 cycle; the load then sits in MEM and forwards with select 11.
- On Branch_ID && !load_use: reg_FD_flush=1. PC_EN_IF and reg_FD_EN stay 1. The ID instruction itself advances normally.
- Simultaneous load_use and Branch_ID: the stall wins and reg_FD_flush=0, because the branch compare operands are invalid. Branch is re-evaluated next cycle.
- forward_ctrl_ls = ls bit of the MEM shadow, which implies the load is in WB.
- All outputs are combinational from the ID inputs and shadow registers. The shadow registers are the only state.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each load_use cycle.
  - flush_cnt increments on each reg_FD_flush cycle.
  - Both wrap modulo 2^CNT_W and clear on reset.
- Undefined: no counter registers; stall_cnt and flush_cnt are tied to 0.

Test Plan:
- lw x5 then add x6,x5,x7 → one cycle with PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1; next cycle forward_ctrl_A=11; stall_cnt=1 (feature on).
- add x5 then sub x8,x7,x5 back-to-back → forward_ctrl_B=01, no stall. With one independent op between them → forward_ctrl_B=10.
- lw x5 then sw x5,0(x9) → no stall; two cycles later forward_ctrl_ls=1 for exactly one cycle.
- Branch_ID=1 with no hazard → reg_FD_flush=1, PC_EN_IF=1. Branch_ID=1 during load_use → reg_FD_flush=0, stall only.
- Writes and reads of x0 (add x0 then add x1,x0,x0) → forward selects 00, no stall.
- rst_n pulsed low while a load sits in EX → next ID use of its rd gives no stall and forward selects 00.
